wire_or_lines: RTL and testbench

Parametrised N-channel manager for active-low open-drain wire-OR lines (IRQ, NMI, RES and future lines). Each channel drives its pad only while asserting and synchronises and glitch-filters the pad readback. It reports the line state as active-high, with edge pulses. It also tells our own assertion apart from another device holding the line low. Sits between the pad ring and main, replacing per-signal inline inversion/OE logic.

---
 rtl/wire_or_lines.sv | 135 +++++++++++++
 tb/tb_wire_or_lines.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wire_or_lines.sv
// Per-channel manager for active-low open-drain wire-OR lines: drive, resync, glitch filter, edges, external-hold detection.
// Optional stuck-line detection is built when WIRE_OR_STUCK_DETECT_EN is defined.
module wire_or_lines #(
  parameter int unsigned CHANNELS       = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned RELEASE_CYCLES = 2,
  parameter int unsigned STUCK_CYCLES   = 65535
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [CHANNELS-1:0] assert_i,
  input  logic [CHANNELS-1:0] line_n_i,
  output logic [CHANNELS-1:0] line_n_o,
  output logic [CHANNELS-1:0] line_n_oe,
  output logic [CHANNELS-1:0] line_o,
  output logic [CHANNELS-1:0] external_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] stuck_o
);

  localparam int unsigned FW         = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned BLANK_LOAD = RELEASE_CYCLES + SYNC_STAGES + FILTER_CYCLES;
  localparam int unsigned BW         = $clog2(BLANK_LOAD + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_LOAD);

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [FW-1:0]          filt_cnt [CHANNELS];
  logic [BW-1:0]          blank_cnt [CHANNELS];
  logic [CHANNELS-1:0]    sync_line;
  logic [CHANNELS-1:0]    change;
  logic [CHANNELS-1:0]    oe_q;
  logic [CHANNELS-1:0]    line_q;
  logic [CHANNELS-1:0]    ext_q;
  logic [CHANNELS-1:0]    rise_q;
  logic [CHANNELS-1:0]    fall_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign sync_line[i] = ~sync_q[i][SYNC_STAGES-1];
    assign change[i]    = (sync_line[i] != line_q[i]) && (filt_cnt[i] == FILT_LAST);

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        sync_q[i] <= '1;
      end else begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], line_n_i[i]};
      end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        filt_cnt[i] <= '0;
        line_q[i]   <= 1'b0;
        rise_q[i]   <= 1'b0;
        fall_q[i]   <= 1'b0;
      end else begin
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
        if (sync_line[i] == line_q[i]) begin
          filt_cnt[i] <= '0;
        end else if (change[i]) begin
          line_q[i]   <= sync_line[i];
          filt_cnt[i] <= '0;
          rise_q[i]   <= sync_line[i];
          fall_q[i]   <= ~sync_line[i];
        end else begin
          filt_cnt[i] <= filt_cnt[i] + FW'(1);
        end
      end
    end

    // Blanking loads on the edge where the registered enable drops, so the
    // pull-up rise plus the full readback latency is masked after release.
    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        oe_q[i]      <= 1'b0;
        blank_cnt[i] <= '0;
        ext_q[i]     <= 1'b0;
      end else begin
        oe_q[i] <= assert_i[i];
        if (assert_i[i]) begin
          blank_cnt[i] <= '0;
        end else if (oe_q[i]) begin
          blank_cnt[i] <= BLANK_INIT;
        end else if (blank_cnt[i] != '0) begin
          blank_cnt[i] <= blank_cnt[i] - BW'(1);
        end
        ext_q[i] <= line_q[i] & ~oe_q[i] & (blank_cnt[i] == '0);
      end
    end
  end

`ifdef WIRE_OR_STUCK_DETECT_EN
  localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_CYCLES);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

  logic [SW-1:0]       stuck_cnt [CHANNELS];
  logic [CHANNELS-1:0] stuck_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_stuck
    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        stuck_cnt[i] <= '0;
        stuck_q[i]   <= 1'b0;
      end else begin
        if (!ext_q[i]) begin
          stuck_cnt[i] <= '0;
        end else if (stuck_cnt[i] != STUCK_MAX) begin
          stuck_cnt[i] <= stuck_cnt[i] + SW'(1);
        end
        if (change[i] && !sync_line[i]) begin
          stuck_q[i] <= 1'b0;
        end else if (ext_q[i] && stuck_cnt[i] == STUCK_LAST) begin
          stuck_q[i] <= 1'b1;
        end
      end
    end
  end

  assign stuck_o = stuck_q;
`else
  assign stuck_o = '0;
`endif

  assign line_n_o   = '0;
  assign line_n_oe  = oe_q;
  assign line_o     = line_q;
  assign external_o = ext_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;

endmodule

// File: tb/tb_wire_or_lines.sv
// Directed self-checking bench for wire_or_lines; pads modelled as a wire-AND of
// the external devices and our own open-drain drive.
module tb_wire_or_lines;

  logic       clock_i;
  logic       reset_i;
  logic [2:0] assert_i;
  logic [2:0] ext_n;
  logic [2:0] line_n_i;
  logic [2:0] line_n_o;
  logic [2:0] line_n_oe;
  logic [2:0] line_o;
  logic [2:0] external_o;
  logic [2:0] rise_o;
  logic [2:0] fall_o;
  logic [2:0] stuck_o;

  int unsigned checks;
  int unsigned errors;
  logic [2:0]  seen;

`ifdef WIRE_OR_STUCK_DETECT_EN
  localparam logic STUCK_EXP = 1'b1;
`else
  localparam logic STUCK_EXP = 1'b0;
`endif

  wire_or_lines #(
    .CHANNELS(3),
    .SYNC_STAGES(2),
    .FILTER_CYCLES(4),
    .RELEASE_CYCLES(2),
    .STUCK_CYCLES(10)
  ) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .assert_i(assert_i),
    .line_n_i(line_n_i),
    .line_n_o(line_n_o),
    .line_n_oe(line_n_oe),
    .line_o(line_o),
    .external_o(external_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .stuck_o(stuck_o)
  );

  assign line_n_i = ext_n & ~line_n_oe;

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  // Advance n edges, OR-ing each post-edge value of the selected output into seen.
  task automatic tick_watch(input int n, input int sel);
    for (int k = 0; k < n; k++) begin
      tick(1);
      case (sel)
        0:       seen = seen | external_o;
        default: seen = seen | line_o | rise_o;
      endcase
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_i  = 1'b1;
    assert_i = 3'b000;
    ext_n    = 3'b010;

    // 1: reset with pads 0 and 2 held low
    tick(2);
    check("rst_oe", line_n_oe, 3'b000);
    check("rst_line", line_o, 3'b000);
    check("rst_ext", external_o, 3'b000);
    check("rst_edges", {rise_o, fall_o}, 6'b0);
    check("rst_stuck", stuck_o, 3'b000);
    check("pad_value", line_n_o, 3'b000);
    reset_i = 1'b0;
    tick(5);
    check("post_rst_e5", line_o, 3'b000);
    tick(1);
    check("post_rst_e6", line_o, 3'b101);
    check("post_rst_rise", rise_o, 3'b101);
    tick(1);
    check("post_rst_rise_end", rise_o, 3'b000);
    check("post_rst_hold", line_o, 3'b101);
    ext_n = 3'b111;
    tick(10);
    check("idle_after_1", line_o, 3'b000);

    // 2: glitch filter on channel 1
    ext_n[1] = 1'b0;
    tick(3);
    ext_n[1] = 1'b1;
    seen = '0;
    tick_watch(8, 1);
    check("glitch3_ignored", seen, 3'b000);
    ext_n[1] = 1'b0;
    tick(4);
    ext_n[1] = 1'b1;
    tick(1);
    check("low4_e5", line_o, 3'b000);
    tick(1);
    check("low4_e6", line_o, 3'b010);
    check("low4_rise", rise_o, 3'b010);
    tick(1);
    check("low4_rise_end", rise_o, 3'b000);
    tick(2);
    check("high_pre_fall", line_o, 3'b010);
    tick(1);
    check("high_fall_line", line_o, 3'b000);
    check("high_fall_pulse", fall_o, 3'b010);
    tick(1);
    check("high_fall_end", fall_o, 3'b000);

    // 3: self-assert on channel 0, looped back through the pad
    seen = '0;
    assert_i[0] = 1'b1;
    tick(1);
    check("self_oe", line_n_oe, 3'b001);
    tick_watch(5, 0);
    check("self_line_e6", line_o, 3'b000);
    tick_watch(1, 0);
    check("self_line_e7", line_o, 3'b001);
    tick_watch(3, 0);
    assert_i[0] = 1'b0;
    tick_watch(1, 0);
    check("self_oe_off", line_n_oe, 3'b000);
    tick_watch(5, 0);
    check("self_rel_e6", line_o, 3'b001);
    tick_watch(1, 0);
    check("self_rel_e7", line_o, 3'b000);
    tick_watch(6, 0);
    check("self_ext_never", seen, 3'b000);

    // 4: device B holds channel 2 across our release
    seen = '0;
    assert_i[2] = 1'b1;
    ext_n[2]    = 1'b0;
    tick_watch(10, 0);
    check("hold_line", line_o, 3'b100);
    check("hold_ext_driving", seen, 3'b000);
    assert_i[2] = 1'b0;
    tick(9);
    check("hold_blanked", external_o, 3'b000);
    tick(1);
    check("hold_ext_set", external_o, 3'b100);
    ext_n[2] = 1'b1;
    tick(10);
    check("hold_released", {line_o, external_o}, 6'b0);

    // 5: async reset in the middle of a filter run
    ext_n[0]    = 1'b0;
    assert_i[0] = 1'b1;
    tick(4);
    check("mid_oe", line_n_oe, 3'b001);
    check("mid_line", line_o, 3'b000);
    reset_i = 1'b1;
    #1;
    check("async_oe", line_n_oe, 3'b000);
    check("async_line", line_o, 3'b000);
    assert_i[0] = 1'b0;
    tick(2);
    reset_i = 1'b0;
    tick(5);
    check("resync_e5", line_o, 3'b000);
    tick(1);
    check("resync_e6", line_o, 3'b001);
    ext_n[0] = 1'b1;
    tick(10);

    // 6: external hold on channel 1 long enough to trip stuck detection
    ext_n[1] = 1'b0;
    tick(16);
    check("stuck_ext", external_o, 3'b010);
    check("stuck_e16", stuck_o, 3'b000);
    tick(1);
    check("stuck_e17", stuck_o[1], STUCK_EXP);
    tick(3);
    ext_n[1] = 1'b1;
    tick(5);
    check("stuck_held", stuck_o[1], STUCK_EXP);
    tick(1);
    check("stuck_clear_fall", fall_o, 3'b010);
    check("stuck_clear", stuck_o, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
